// File: rtl/pc_sequencer_pkg.sv
// rtl/pc_sequencer_pkg.sv - shared widths, opcode and state encoding for the fetch sequencer
package pc_sequencer_pkg;

    localparam int PCS_WORD  = 64;
    localparam int INSTR_LEN = 32;

    localparam logic [5:0] OP_B = 6'b000101;

    typedef enum logic [1:0] {
        PCS_IDLE  = 2'd0,
        PCS_FETCH = 2'd1,
        PCS_HOLD  = 2'd2
    } pcs_state_t;

endpackage

// File: rtl/pcs_br_offset.sv
// rtl/pcs_br_offset.sv - imm26 to sign-extended byte offset for unconditional B
module pcs_br_offset #(
    parameter int WORD = 64
) (
    input  logic [25:0]     imm26,
    output logic [WORD-1:0] offset
);

    assign offset = {{(WORD-28){imm26[25]}}, imm26, 2'b00};

endmodule

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - LEGv8 fetch sequencer: PC, one-at-a-time imem requests, fetch buffer, redirects
// Optional early redirect on unconditional B under PC_SEQ_STATIC_BRANCH_EN.
module pc_sequencer
    import pc_sequencer_pkg::*;
#(
    parameter int              WORD     = PCS_WORD,
    parameter logic [WORD-1:0] RESET_PC = '0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic                 imem_req,
    output logic [WORD-1:0]      imem_addr,
    input  logic                 imem_ack,
    input  logic [INSTR_LEN-1:0] imem_rdata,
    output logic                 if_valid,
    output logic [INSTR_LEN-1:0] if_instr,
    output logic [WORD-1:0]      if_pc,
    input  logic                 id_ready,
    input  logic                 br_taken,
    input  logic [WORD-1:0]      br_target
);

    pcs_state_t           state, state_n;
    logic [WORD-1:0]      pc, pc_n, addr_n, seq_pc;
    logic                 drop, drop_n, valid_n;
    logic [INSTR_LEN-1:0] instr_n;
    logic [WORD-1:0]      ifpc_n;

`ifdef PC_SEQ_STATIC_BRANCH_EN
    logic [WORD-1:0] br_offset;

    pcs_br_offset #(.WORD(WORD)) u_br_offset (
        .imm26  (imem_rdata[25:0]),
        .offset (br_offset)
    );

    assign seq_pc = (imem_rdata[31:26] == OP_B) ? imem_addr + br_offset
                                                : imem_addr + {{(WORD-3){1'b0}}, 3'd4};
`else
    assign seq_pc = imem_addr + {{(WORD-3){1'b0}}, 3'd4};
`endif

    assign imem_req = (state == PCS_FETCH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= PCS_IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        valid_n = if_valid;
        instr_n = if_instr;
        ifpc_n  = if_pc;
        case (state)
            PCS_IDLE: state_n = PCS_FETCH;
            PCS_FETCH: begin
                if (imem_ack) begin
                    if (drop) begin
                        drop_n = 1'b0;
                    end else begin
                        valid_n = 1'b1;
                        instr_n = imem_rdata;
                        ifpc_n  = imem_addr;
                        pc_n    = seq_pc;
                        state_n = PCS_HOLD;
                    end
                end
            end
            PCS_HOLD: begin
                if (id_ready) begin
                    valid_n = 1'b0;
                    state_n = PCS_FETCH;
                end
            end
            default: state_n = PCS_IDLE;
        endcase
        // A redirect overrides everything; an in-flight request must still complete, so mark it stale.
        if (br_taken) begin
            pc_n    = {br_target[WORD-1:2], 2'b00};
            valid_n = 1'b0;
            instr_n = if_instr;
            ifpc_n  = if_pc;
            state_n = PCS_FETCH;
            if (state == PCS_FETCH) drop_n = !imem_ack;
        end
        addr_n = drop_n ? imem_addr : pc_n;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc        <= RESET_PC;
            imem_addr <= RESET_PC;
            drop      <= 1'b0;
            if_valid  <= 1'b0;
            if_instr  <= '0;
            if_pc     <= '0;
        end else begin
            pc        <= pc_n;
            imem_addr <= addr_n;
            drop      <= drop_n;
            if_valid  <= valid_n;
            if_instr  <= instr_n;
            if_pc     <= ifpc_n;
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - self-checking bench for pc_sequencer against a transaction-level fetch model
module tb_pc_sequencer;

`ifdef PC_SEQ_STATIC_BRANCH_EN
    localparam bit STATIC_EN = 1'b1;
`else
    localparam bit STATIC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [63:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [63:0] if_pc;
    logic        id_ready = 1'b0;
    logic        br_taken = 1'b0;
    logic [63:0] br_target = '0;

    always #5 clk = ~clk;

    pc_sequencer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_instr   (if_instr),
        .if_pc      (if_pc),
        .id_ready   (id_ready),
        .br_taken   (br_taken),
        .br_target  (br_target)
    );

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    int          delay      = 1;
    bit          want_ready = 1'b1;
    bit          br_now     = 1'b0;
    logic [63:0] br_tgt     = '0;

    bit          outstanding = 1'b0;
    logic [63:0] out_addr    = '0;
    int          wait_cnt    = 0;
    logic [63:0] model_pc    = '0;
    bit          discard     = 1'b0;
    bit          buf_full    = 1'b0;
    logic [63:0] buf_pc      = '0;
    logic [31:0] buf_instr   = '0;

    int          n_req         = 0;
    logic [63:0] last_new_addr = '0;
    bit          prev_valid    = 1'b0;
    bit          valid_seen    = 1'b0;
    bit          ok;
    int          valid_rise[$];
    logic [63:0] req_addrs[$];
    logic [63:0] pc0;
    logic [31:0] ins0;

    function automatic logic [31:0] memf(input logic [63:0] a);
        if (a == 64'h100) return 32'h17FF_FFC9;
        return (a[31:0] * 32'h9E37_79B1) ^ 32'h5BD1_E995;
    endfunction

    function automatic logic [63:0] next_pc(input logic [63:0] a, input logic [31:0] ins);
        if (STATIC_EN && ins[31:26] == 6'b000101)
            return a + 64'(longint'($signed(ins[25:0])) * 4);
        return a + 64'd4;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One clock: sample at the falling edge, score against the model, then drive the next edge's inputs.
    task automatic step();
        logic ack;
        @(negedge clk);
        cyc++;
        if (outstanding) begin
            check("req_held", 64'(imem_req), 64'd1);
            check("addr_stable", imem_addr, out_addr);
        end else if (imem_req) begin
            check("req_addr", imem_addr, model_pc);
            outstanding   = 1'b1;
            out_addr      = imem_addr;
            wait_cnt      = 0;
            n_req++;
            last_new_addr = imem_addr;
            req_addrs.push_back(imem_addr);
        end
        check("if_valid", 64'(if_valid), 64'(buf_full));
        if (buf_full) begin
            check("if_pc", if_pc, buf_pc);
            check("if_instr", 64'(if_instr), 64'(buf_instr));
        end
        if (if_valid && !prev_valid) valid_rise.push_back(cyc);
        prev_valid = if_valid;
        if (if_valid) valid_seen = 1'b1;

        ack        = outstanding && (wait_cnt >= delay);
        imem_ack   = ack;
        imem_rdata = ack ? memf(out_addr) : $urandom;
        if (outstanding && !ack) wait_cnt++;
        id_ready   = want_ready;
        br_taken   = br_now;
        br_target  = br_tgt;

        if (buf_full && want_ready) buf_full = 1'b0;
        if (br_now) begin
            model_pc = {br_tgt[63:2], 2'b00};
            buf_full = 1'b0;
            if (outstanding && !ack) discard = 1'b1;
            else if (ack)            discard = 1'b0;
        end else if (ack) begin
            if (discard) begin
                discard = 1'b0;
            end else begin
                buf_full  = 1'b1;
                buf_pc    = out_addr;
                buf_instr = imem_rdata;
                model_pc  = next_pc(out_addr, imem_rdata);
            end
        end
        if (ack) outstanding = 1'b0;
        br_now = 1'b0;
    endtask

    task automatic wait_new_req(output bit got);
        int r0 = n_req;
        got = 1'b0;
        valid_seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (n_req != r0) begin
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic model_reset();
        outstanding = 1'b0;
        model_pc    = '0;
        discard     = 1'b0;
        buf_full    = 1'b0;
        prev_valid  = 1'b0;
        imem_ack    = 1'b0;
        br_taken    = 1'b0;
        br_now      = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   64'(imem_req), 64'd0);
        check({tag, "_addr"},  imem_addr, 64'd0);
        check({tag, "_valid"}, 64'(if_valid), 64'd0);
        check({tag, "_instr"}, 64'(if_instr), 64'd0);
        check({tag, "_pc"},    if_pc, 64'd0);
    endtask

    initial begin
        // Reset state
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // 1: sequential fetch, 1-cycle memory, decode always ready
        delay = 1; want_ready = 1'b1;
        valid_rise.delete(); req_addrs.delete();
        repeat (10) step();
        check("seq_count", 64'(req_addrs.size() >= 3), 64'd1);
        check("seq_rise_count", 64'(valid_rise.size() >= 3), 64'd1);
        if (req_addrs.size() >= 3) begin
            check("seq_addr0", req_addrs[0], 64'h0);
            check("seq_addr1", req_addrs[1], 64'h4);
            check("seq_addr2", req_addrs[2], 64'h8);
        end
        if (valid_rise.size() >= 3) begin
            check("rate_a", 64'(valid_rise[1] - valid_rise[0]), 64'd3);
            check("rate_b", 64'(valid_rise[2] - valid_rise[1]), 64'd3);
        end

        // 2: decode stall holds the buffer and blocks new requests
        want_ready = 1'b0;
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (if_valid) begin ok = 1'b1; break; end
        end
        check("stall_fill", 64'(ok), 64'd1);
        pc0 = if_pc; ins0 = if_instr;
        for (int i = 0; i < 5; i++) begin
            step();
            check("stall_req", 64'(imem_req), 64'd0);
            check("stall_pc", if_pc, pc0);
            check("stall_instr", 64'(if_instr), 64'(ins0));
        end
        want_ready = 1'b1;
        step();
        step();
        check("resume_req", 64'(imem_req), 64'd1);
        check("resume_addr", imem_addr, next_pc(pc0, ins0));

        // 3: redirect while a slow request is outstanding
        delay = 3;
        wait_new_req(ok);
        check("drop_wait", 64'(ok), 64'd1);
        br_now = 1'b1; br_tgt = 64'h203;
        step();
        wait_new_req(ok);
        check("drop_wait2", 64'(ok), 64'd1);
        check("drop_addr", last_new_addr, 64'h200);
        check("drop_no_valid", 64'(valid_seen), 64'd0);

        // 4: redirect coincident with the ack
        delay = 1;
        wait_new_req(ok);
        check("coin_wait", 64'(ok), 64'd1);
        br_now = 1'b1; br_tgt = 64'h340;
        step();
        wait_new_req(ok);
        check("coin_wait2", 64'(ok), 64'd1);
        check("coin_addr", last_new_addr, 64'h340);
        check("coin_no_valid", 64'(valid_seen), 64'd0);

        // 5: B at 0x100 with imm26 = -55 words
        br_now = 1'b1; br_tgt = 64'h100;
        step();
        for (int i = 0; i < 4; i++) begin
            wait_new_req(ok);
            if (last_new_addr == 64'h100) break;
        end
        check("b_fetch", last_new_addr, 64'h100);
        wait_new_req(ok);
        check("b_wait", 64'(ok), 64'd1);
        check("b_next", last_new_addr, STATIC_EN ? 64'h24 : 64'h104);

        // 6: asynchronous reset in the middle of a fetch
        delay = 3;
        wait_new_req(ok);
        step();
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("async");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_new_req(ok);
        check("restart_wait", 64'(ok), 64'd1);
        check("restart_addr", last_new_addr, 64'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            want_ready = ($urandom_range(0, 9) < 7);
            delay      = int'($urandom_range(0, 3));
            br_now     = ($urandom_range(0, 19) == 0);
            br_tgt     = {$urandom, $urandom};
            step();
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
